// File: rtl/ctrl_pkg.sv
// Shared types and opcode tables for the hardwired datapath sequencer.
// Opcode classification lives here so decode and any future tooling agree.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_HALT,
    ST_FAULT
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU3,
    CLS_MULDIV,
    CLS_UNARY,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_AND  = 5'b00101;
  localparam logic [4:0] OPC_OR   = 5'b00110;
  localparam logic [4:0] OPC_SHR  = 5'b00111;
  localparam logic [4:0] OPC_SHRA = 5'b01000;
  localparam logic [4:0] OPC_SHL  = 5'b01001;
  localparam logic [4:0] OPC_ROR  = 5'b01010;
  localparam logic [4:0] OPC_ROL  = 5'b01011;
  localparam logic [4:0] OPC_MUL  = 5'b01111;
  localparam logic [4:0] OPC_DIV  = 5'b10000;
  localparam logic [4:0] OPC_NEG  = 5'b10001;
  localparam logic [4:0] OPC_NOT  = 5'b10010;
  localparam logic [4:0] OPC_NOP  = 5'b11010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SHR  = 4'd4;
  localparam logic [3:0] ALU_SHRA = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;
  localparam logic [3:0] ALU_ROR  = 4'd7;
  localparam logic [3:0] ALU_ROL  = 4'd8;
  localparam logic [3:0] ALU_MUL  = 4'd9;
  localparam logic [3:0] ALU_DIV  = 4'd10;
  localparam logic [3:0] ALU_NEG  = 4'd11;
  localparam logic [3:0] ALU_NOT  = 4'd12;

  function automatic op_class_t op_class(input logic [4:0] op);
    case (op)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR,
      OPC_SHRA, OPC_SHL, OPC_ROR, OPC_ROL: return CLS_ALU3;
      OPC_MUL, OPC_DIV:                    return CLS_MULDIV;
      OPC_NEG, OPC_NOT:                    return CLS_UNARY;
      OPC_NOP:                             return CLS_NOP;
      OPC_HALT:                            return CLS_HALT;
      default:                             return CLS_ILLEGAL;
    endcase
  endfunction

  // Non-ALU opcodes map to 0; their operation output is never asserted anyway.
  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      OPC_SUB:  return ALU_SUB;
      OPC_AND:  return ALU_AND;
      OPC_OR:   return ALU_OR;
      OPC_SHR:  return ALU_SHR;
      OPC_SHRA: return ALU_SHRA;
      OPC_SHL:  return ALU_SHL;
      OPC_ROR:  return ALU_ROR;
      OPC_ROL:  return ALU_ROL;
      OPC_MUL:  return ALU_MUL;
      OPC_DIV:  return ALU_DIV;
      OPC_NEG:  return ALU_NEG;
      OPC_NOT:  return ALU_NOT;
      default:  return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/reg_select.sv
// Turns a 4-bit GPR index into a one-hot select; all zeros when disabled.
module reg_select (
  input  logic [3:0]  index,
  input  logic        enable,
  output logic [15:0] onehot
);

  assign onehot = enable ? (16'h0001 << index) : 16'h0000;

endmodule

// File: rtl/datapath_ctrl.sv
// Hardwired micro-step sequencer: one bus source, register loads and ALU op per step.
// Outputs are a pure decode of the state register and the instruction fields.
module datapath_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             run,
  input  logic             mem_ready,
  input  logic [31:0]      IR,
  output logic             PCout,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             MDRout,
  output logic             HIout,
  output logic             LOout,
  output logic             MARin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin_high,
  output logic             Zin_low,
  output logic             HIin,
  output logic             LOin,
  output logic             IncPC,
  output logic             Read,
  output logic [15:0]      Rout,
  output logic [15:0]      Rin,
  output logic [3:0]       operation,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  import ctrl_pkg::*;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic [4:0]        op_q, cur_op;
  logic [3:0]        ra_q, rb_q, rc_q, cur_ra, cur_rb, cur_rc;
  op_class_t         cls;
  logic [3:0]        alu_op;
  logic              retire;
  logic              rout_en, rin_en;
  logic [3:0]        rout_idx;
  logic              unused_ir_bits;

  assign unused_ir_bits = ^IR[14:0];

  // IR is fresh in T3; later steps use the copy taken at the end of T3.
  assign cur_op = (state == ST_T3) ? IR[31:27] : op_q;
  assign cur_ra = (state == ST_T3) ? IR[26:23] : ra_q;
  assign cur_rb = (state == ST_T3) ? IR[22:19] : rb_q;
  assign cur_rc = (state == ST_T3) ? IR[18:15] : rc_q;
  assign cls    = op_class(cur_op);
  assign alu_op = alu_code(cur_op);

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      instr_count <= '0;
      op_q        <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      rc_q        <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_next;
      if (retire) instr_count <= instr_count + CNT_W'(1);
      if (state == ST_T3) begin
        op_q <= IR[31:27];
        ra_q <= IR[26:23];
        rb_q <= IR[22:19];
        rc_q <= IR[18:15];
      end
    end
  end

  always_comb begin
    next_state = state;
    wait_next  = wait_cnt;
    retire     = 1'b0;
    PCout      = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    MDRout     = 1'b0;
    HIout      = 1'b0;
    LOout      = 1'b0;
    MARin      = 1'b0;
    PCin       = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zin_high   = 1'b0;
    Zin_low    = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    operation  = 4'd0;
    rout_en    = 1'b0;
    rout_idx   = 4'd0;
    rin_en     = 1'b0;

    case (state)
      ST_IDLE: if (run) next_state = ST_T0;
      ST_T0: begin
        PCout      = 1'b1;
        MARin      = 1'b1;
        IncPC      = 1'b1;
        Zin_low    = 1'b1;
        next_state = ST_T1;
      end
      ST_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (mem_ready) begin
          next_state = ST_T2;
          wait_next  = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          next_state = ST_FAULT;
          wait_next  = '0;
        end else begin
          wait_next = wait_cnt + WAIT_W'(1);
        end
      end
      ST_T2: begin
        MDRout     = 1'b1;
        IRin       = 1'b1;
        next_state = ST_T3;
      end
      ST_T3: begin
        case (cls)
          CLS_ALU3: begin
            rout_en    = 1'b1;
            rout_idx   = cur_rb;
            Yin        = 1'b1;
            next_state = ST_T4;
          end
          CLS_MULDIV: begin
            rout_en    = 1'b1;
            rout_idx   = cur_ra;
            Yin        = 1'b1;
            next_state = ST_T4;
          end
          CLS_UNARY: begin
            rout_en    = 1'b1;
            rout_idx   = cur_rb;
            operation  = alu_op;
            Zin_low    = 1'b1;
            next_state = ST_T5;
          end
          CLS_NOP: begin
            retire     = 1'b1;
            next_state = run ? ST_T0 : ST_IDLE;
          end
          CLS_HALT: begin
            retire     = 1'b1;
            next_state = ST_HALT;
          end
          default: next_state = ST_FAULT;
        endcase
      end
      ST_T4: begin
        rout_en   = 1'b1;
        operation = alu_op;
        Zin_low   = 1'b1;
        if (cls == CLS_MULDIV) begin
          rout_idx = cur_rb;
          Zin_high = 1'b1;
        end else begin
          rout_idx = cur_rc;
        end
        next_state = ST_T5;
      end
      ST_T5: begin
        Zlowout = 1'b1;
        if (cls == CLS_MULDIV) begin
          LOin       = 1'b1;
          next_state = ST_T6;
        end else begin
          rin_en     = 1'b1;
          retire     = 1'b1;
          next_state = run ? ST_T0 : ST_IDLE;
        end
      end
      ST_T6: begin
        Zhighout   = 1'b1;
        HIin       = 1'b1;
        retire     = 1'b1;
        next_state = run ? ST_T0 : ST_IDLE;
      end
      ST_HALT:  next_state = ST_HALT;
      ST_FAULT: next_state = ST_FAULT;
      default:  next_state = ST_IDLE;
    endcase
  end

  reg_select u_rout (
    .index  (rout_idx),
    .enable (rout_en),
    .onehot (Rout)
  );

  reg_select u_rin (
    .index  (cur_ra),
    .enable (rin_en),
    .onehot (Rin)
  );

  assign busy   = !(state inside {ST_IDLE, ST_HALT, ST_FAULT});
  assign halted = (state == ST_HALT);
  assign fault  = (state == ST_FAULT);

endmodule

// File: tb/tb_datapath_ctrl.sv
// Scoreboarded bench for datapath_ctrl: per-instruction step expectations are
// queued when the instruction is launched and compared every cycle.
module tb_datapath_ctrl;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 16;

  localparam int C_ALU = 0, C_MULDIV = 1, C_UNARY = 2, C_NOP = 3, C_HALT = 4, C_ILL = 5;
  localparam int F_IDLE = 0, F_HALT = 1, F_FAULT = 2;

  logic             Clock = 1'b0;
  logic             clear, run, mem_ready;
  logic [31:0]      IR;
  logic             PCout, Zlowout, Zhighout, MDRout, HIout, LOout;
  logic             MARin, PCin, MDRin, IRin, Yin, Zin_high, Zin_low, HIin, LOin;
  logic             IncPC, Read;
  logic [15:0]      Rout, Rin;
  logic [3:0]       operation;
  logic             busy, halted, fault;
  logic [CNT_W-1:0] instr_count;

  typedef struct packed {
    logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout;
    logic MARin, PCin, MDRin, IRin, Yin, Zin_high, Zin_low, HIin, LOin;
    logic IncPC, Read;
    logic [15:0] Rout;
    logic [15:0] Rin;
    logic [3:0]  operation;
    logic busy, halted, fault;
  } ctl_t;

  typedef struct {
    ctl_t c;
    bit   isT1;
  } step_t;

  typedef struct {
    string      name;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    int         stall;
    int         cls;
    logic [3:0] expOp;
    int         expBusy;
    int         expCount;
    int         fin;
  } vec_t;

  step_t sbq[$];
  vec_t  vecs[12];
  int    checks = 0;
  int    errors = 0;

  datapath_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .clear(clear), .run(run), .mem_ready(mem_ready), .IR(IR),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .Zin_high(Zin_high), .Zin_low(Zin_low),
    .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read), .Rout(Rout),
    .Rin(Rin), .operation(operation), .busy(busy), .halted(halted),
    .fault(fault), .instr_count(instr_count)
  );

  always #5 Clock = ~Clock;

  function automatic ctl_t sample();
    return {PCout, Zlowout, Zhighout, MDRout, HIout, LOout,
            MARin, PCin, MDRin, IRin, Yin, Zin_high, Zin_low, HIin, LOin,
            IncPC, Read, Rout, Rin, operation, busy, halted, fault};
  endfunction

  function automatic logic [31:0] mkIr(input logic [4:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'b0};
  endfunction

  function automatic vec_t mkVec(input string name, input logic [4:0] op, input int ra,
                                 input int rb, input int rc, input int stall, input int cls,
                                 input int expOp, input int expBusy, input int expCount,
                                 input int fin);
    vec_t v;
    v.name = name; v.op = op; v.ra = 4'(ra); v.rb = 4'(rb); v.rc = 4'(rc);
    v.stall = stall; v.cls = cls; v.expOp = 4'(expOp); v.expBusy = expBusy;
    v.expCount = expCount; v.fin = fin;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic checkBus(input string name);
    int n;
    n = int'(PCout) + int'(Zlowout) + int'(Zhighout) + int'(MDRout) + int'(HIout)
      + int'(LOout) + $countones(Rout);
    checkOutput({name, "_one_bus_source"}, 64'(n <= 1), 64'd1);
  endtask

  task automatic pushStep(input ctl_t c, input bit t1);
    step_t s;
    s.c = c;
    s.isT1 = t1;
    sbq.push_back(s);
  endtask

  // Expected control vector for every cycle of one instruction, plus the settled state after it.
  task automatic pushSteps(input vec_t v);
    ctl_t s;
    s = '0; s.busy = 1; s.PCout = 1; s.MARin = 1; s.IncPC = 1; s.Zin_low = 1;
    pushStep(s, 0);
    s = '0; s.busy = 1; s.Zlowout = 1; s.PCin = 1; s.Read = 1; s.MDRin = 1;
    if (v.stall >= MEM_TIMEOUT) begin
      repeat (MEM_TIMEOUT) pushStep(s, 1);
      s = '0; s.fault = 1;
      pushStep(s, 0);
      return;
    end
    repeat (v.stall + 1) pushStep(s, 1);
    s = '0; s.busy = 1; s.MDRout = 1; s.IRin = 1;
    pushStep(s, 0);
    case (v.cls)
      C_ALU: begin
        s = '0; s.busy = 1; s.Rout = 16'h1 << v.rb; s.Yin = 1;
        pushStep(s, 0);
        s = '0; s.busy = 1; s.Rout = 16'h1 << v.rc; s.operation = v.expOp; s.Zin_low = 1;
        pushStep(s, 0);
        s = '0; s.busy = 1; s.Zlowout = 1; s.Rin = 16'h1 << v.ra;
        pushStep(s, 0);
      end
      C_MULDIV: begin
        s = '0; s.busy = 1; s.Rout = 16'h1 << v.ra; s.Yin = 1;
        pushStep(s, 0);
        s = '0; s.busy = 1; s.Rout = 16'h1 << v.rb; s.operation = v.expOp;
        s.Zin_low = 1; s.Zin_high = 1;
        pushStep(s, 0);
        s = '0; s.busy = 1; s.Zlowout = 1; s.LOin = 1;
        pushStep(s, 0);
        s = '0; s.busy = 1; s.Zhighout = 1; s.HIin = 1;
        pushStep(s, 0);
      end
      C_UNARY: begin
        s = '0; s.busy = 1; s.Rout = 16'h1 << v.rb; s.operation = v.expOp; s.Zin_low = 1;
        pushStep(s, 0);
        s = '0; s.busy = 1; s.Zlowout = 1; s.Rin = 16'h1 << v.ra;
        pushStep(s, 0);
      end
      default: begin
        s = '0; s.busy = 1;
        pushStep(s, 0);
      end
    endcase
    s = '0;
    if (v.fin == F_HALT) s.halted = 1;
    if (v.fin == F_FAULT) s.fault = 1;
    pushStep(s, 0);
  endtask

  task automatic doReset();
    @(negedge Clock);
    clear = 0; run = 0; mem_ready = 0;
    @(negedge Clock);
    clear = 1;
  endtask

  // run is held for the launch edge only, so every instruction returns to IDLE on retire.
  task automatic applyStimulus(input vec_t v);
    int    t1Seen;
    int    busyCycles;
    step_t e;
    ctl_t  act;
    t1Seen = 0;
    busyCycles = 0;
    doReset();
    IR = mkIr(v.op, v.ra, v.rb, v.rc);
    run = 1;
    mem_ready = 0;
    pushSteps(v);
    while (sbq.size() != 0) begin
      @(posedge Clock);
      @(negedge Clock);
      run = 0;
      e = sbq.pop_front();
      act = sample();
      checkOutput({v.name, "_step"}, 64'(act), 64'(e.c));
      checkBus(v.name);
      if (act.busy) busyCycles++;
      if (e.isT1) begin
        t1Seen++;
        mem_ready = (t1Seen > v.stall);
      end
    end
    checkOutput({v.name, "_busy_cycles"}, 64'(busyCycles), 64'(v.expBusy));
    checkOutput({v.name, "_instr_count"}, 64'(instr_count), 64'(v.expCount));
  endtask

  initial begin
    ctl_t x;
    clear = 0; run = 0; mem_ready = 0; IR = '0;
    #1;
    checkOutput("reset_controls", 64'(sample()), 64'd0);
    checkOutput("reset_instr_count", 64'(instr_count), 64'd0);

    vecs[0]  = mkVec("add_r3_r4_r3",   5'b00011,  3,  4, 3,  0, C_ALU,     0,  6, 1, F_IDLE);
    vecs[1]  = mkVec("sub_r1_r2_r5",   5'b00100,  1,  2, 5,  0, C_ALU,     1,  6, 1, F_IDLE);
    vecs[2]  = mkVec("rol_r15_r0_r7",  5'b01011, 15,  0, 7,  0, C_ALU,     8,  6, 1, F_IDLE);
    vecs[3]  = mkVec("mul_r2_r6",      5'b01111,  2,  6, 0,  0, C_MULDIV,  9,  7, 1, F_IDLE);
    vecs[4]  = mkVec("div_r9_r10",     5'b10000,  9, 10, 0,  0, C_MULDIV, 10,  7, 1, F_IDLE);
    vecs[5]  = mkVec("neg_r4_r11",     5'b10001,  4, 11, 0,  0, C_UNARY,  11,  5, 1, F_IDLE);
    vecs[6]  = mkVec("shra_r7_r7_r7",  5'b01000,  7,  7, 7,  0, C_ALU,     5,  6, 1, F_IDLE);
    vecs[7]  = mkVec("nop",            5'b11010,  0,  0, 0,  0, C_NOP,     0,  4, 1, F_IDLE);
    vecs[8]  = mkVec("add_stall3",     5'b00011,  3,  4, 3,  3, C_ALU,     0,  9, 1, F_IDLE);
    vecs[9]  = mkVec("undefined_op",   5'b11111,  1,  2, 3,  0, C_ILL,     0,  4, 0, F_FAULT);
    vecs[10] = mkVec("halt",           5'b11011,  0,  0, 0,  0, C_HALT,    0,  4, 1, F_HALT);
    vecs[11] = mkVec("or_mem_timeout", 5'b00110,  1,  2, 3, 16, C_ALU,     3, 17, 0, F_FAULT);

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // Back-to-back ADDs with run held, then an asynchronous clear in the second T4.
    doReset();
    IR = mkIr(5'b00011, 4'd3, 4'd4, 4'd3);
    run = 1;
    mem_ready = 1;
    for (int k = 1; k <= 11; k++) begin
      @(posedge Clock);
      @(negedge Clock);
      checkBus("b2b");
      if (k == 6)  checkOutput("b2b_first_rin", 64'({Zlowout, Rin}), 64'({1'b1, 16'h0008}));
      if (k == 7)  checkOutput("b2b_next_t0", 64'({PCout, MARin, instr_count}),
                               64'({1'b1, 1'b1, 16'd1}));
      if (k == 11) checkOutput("b2b_second_t4", 64'({Zin_low, operation, Rout}),
                               64'({1'b1, 4'd0, 16'h0008}));
    end
    run = 0;
    clear = 0;
    #1;
    checkOutput("abort_controls", 64'(sample()), 64'd0);
    checkOutput("abort_instr_count", 64'(instr_count), 64'd0);
    @(negedge Clock);
    clear = 1;
    @(posedge Clock);
    @(negedge Clock);
    checkOutput("abort_stays_idle", 64'(busy), 64'd0);

    // NOT with run dropped in T3: finishes through the Rin load, then parks in IDLE.
    doReset();
    IR = mkIr(5'b10010, 4'd5, 4'd9, 4'd0);
    run = 1;
    mem_ready = 1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge Clock);
      @(negedge Clock);
      checkBus("not_rundrop");
      if (k == 4) begin
        x = '0; x.busy = 1; x.Rout = 16'h0200; x.operation = 4'd12; x.Zin_low = 1;
        checkOutput("not_t3", 64'(sample()), 64'(x));
        run = 0;
      end
      if (k == 5) begin
        x = '0; x.busy = 1; x.Zlowout = 1; x.Rin = 16'h0020;
        checkOutput("not_t5_rin", 64'(sample()), 64'(x));
      end
      if (k == 7) begin
        checkOutput("not_idle_after", 64'(sample()), 64'd0);
        checkOutput("not_instr_count", 64'(instr_count), 64'd1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: bench did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
